// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        GAP,
        DONE,
        SWRST
    } reset_seq_state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset deassertion synchronizer: async-set flop chain that shifts in zeros.
module reset_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic ck,
    input  logic rst,
    output logic rst_sync
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Multi-channel reset sequencer: async assert, ordered synchronous release.
// Optional macro RESET_SEQ_REVERSE_ASSERT_EN: SWRST asserts channels high-to-low.
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              sw_req,
    input  logic [NUM_CH-1:0] ch_hold,
    output logic [NUM_CH-1:0] rst_out,
    output logic              done,
    output logic              stalled
);

    localparam int unsigned CNT_W = clog2_min1(GAP_CYCLES + 1);
    localparam int unsigned IDX_W = clog2_min1(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    reset_seq_state_t  state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [NUM_CH-1:0] rst_out_n;
    logic              done_n;
    logic              stalled_n;
    logic              rst_sync;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .ck       (ck),
        .rst      (rst),
        .rst_sync (rst_sync)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= HOLD;
            idx     <= '0;
            cnt     <= '0;
            rst_out <= '1;
            done    <= 1'b0;
            stalled <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            rst_out <= rst_out_n;
            done    <= done_n;
            stalled <= stalled_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        rst_out_n = rst_out;
        done_n    = done;
        stalled_n = stalled;

        case (state)
            HOLD: begin
                if (!rst_sync) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end
            end

            GAP: begin
                if (cnt == CNT_LAST) begin
                    if (!ch_hold[idx]) begin
                        rst_out_n[idx] = 1'b0;
                        stalled_n      = 1'b0;
                        if (idx == IDX_LAST) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                            cnt_n = '0;
                        end
                    end else begin
                        stalled_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DONE: begin
                done_n = 1'b1;
                if (sw_req) begin
                    state_n = SWRST;
                    done_n  = 1'b0;
                    cnt_n   = '0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                    // idx walks down as the assert pointer; it reaches 0 before GAP.
                    idx_n                 = IDX_LAST;
                    rst_out_n[NUM_CH-1]   = 1'b1;
`else
                    idx_n     = '0;
                    rst_out_n = '1;
`endif
                end
            end

            SWRST: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                    if (idx == '0) begin
                        state_n = GAP;
                    end else begin
                        idx_n            = idx - 1'b1;
                        rst_out_n[idx_n] = 1'b1;
                    end
`else
                    state_n = GAP;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed self-checking bench for reset_seq_ctrl (default parameters).
module tb_reset_seq_ctrl;

    logic       ck;
    logic       rst;
    logic       sw_req;
    logic [3:0] ch_hold;
    logic [3:0] rst_out;
    logic       done;
    logic       stalled;

    int unsigned n_cmp;
    int unsigned n_bad;
    int          cur;
    int          e_sw;

    reset_seq_ctrl #(
        .NUM_CH      (4),
        .SYNC_STAGES (2),
        .GAP_CYCLES  (8)
    ) dut (
        .ck      (ck),
        .rst     (rst),
        .sw_req  (sw_req),
        .ch_hold (ch_hold),
        .rst_out (rst_out),
        .done    (done),
        .stalled (stalled)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s@%0d: observed %0h expected %0h", tag, cur, obs, exp);
        end
    endtask

    // Advance to rising edge number e (counted from the last rst release), then settle 1ns.
    task automatic goto(input int e);
        while (cur < e) begin
            @(posedge ck);
            cur++;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge ck);
        #1;
        chk("rst_out_in_reset", {28'd0, rst_out}, 32'hF);
        chk("done_in_reset", {31'd0, done}, 32'h0);
        chk("stalled_in_reset", {31'd0, stalled}, 32'h0);
        @(negedge ck);
        rst = 1'b0;
        cur = 0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cur     = 0;
        sw_req  = 1'b0;
        ch_hold = 4'b0000;

        // Power-on sequence
        do_reset(5);
        goto(10); chk("po_rst_out", {28'd0, rst_out}, 32'hF);
        goto(11); chk("po_rst_out", {28'd0, rst_out}, 32'hE);
        goto(18); chk("po_rst_out", {28'd0, rst_out}, 32'hE);
        goto(19); chk("po_rst_out", {28'd0, rst_out}, 32'hC);
        goto(27); chk("po_rst_out", {28'd0, rst_out}, 32'h8);
        goto(34); chk("po_done", {31'd0, done}, 32'h0);
        goto(35); chk("po_rst_out", {28'd0, rst_out}, 32'h0);
        chk("po_done", {31'd0, done}, 32'h1);

        // Software re-sequence from DONE, request seen at edge 41
        goto(40); sw_req = 1'b1;
        e_sw = 41;
        goto(e_sw); sw_req = 1'b0;
        chk("sw_done_drop", {31'd0, done}, 32'h0);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
        chk("sw_rst_out", {28'd0, rst_out}, 32'h8);
        goto(e_sw + 7);  chk("sw_rst_out", {28'd0, rst_out}, 32'h8);
        goto(e_sw + 8);  chk("sw_rst_out", {28'd0, rst_out}, 32'hC);
        goto(e_sw + 16); chk("sw_rst_out", {28'd0, rst_out}, 32'hE);
        goto(e_sw + 24); chk("sw_rst_out", {28'd0, rst_out}, 32'hF);
        goto(e_sw + 39); chk("sw_rst_out", {28'd0, rst_out}, 32'hF);
        goto(e_sw + 40); chk("sw_rst_out", {28'd0, rst_out}, 32'hE);
        goto(e_sw + 64); chk("sw_done", {31'd0, done}, 32'h1);
        chk("sw_rst_out", {28'd0, rst_out}, 32'h0);
`else
        chk("sw_rst_out", {28'd0, rst_out}, 32'hF);
        goto(e_sw + 15); chk("sw_rst_out", {28'd0, rst_out}, 32'hF);
        goto(e_sw + 16); chk("sw_rst_out", {28'd0, rst_out}, 32'hE);
        goto(e_sw + 39); chk("sw_done", {31'd0, done}, 32'h0);
        goto(e_sw + 40); chk("sw_done", {31'd0, done}, 32'h1);
        chk("sw_rst_out", {28'd0, rst_out}, 32'h0);
`endif

        // sw_req while still sequencing is ignored
        do_reset(2);
        goto(14); sw_req = 1'b1;
        goto(15); sw_req = 1'b0;
        goto(18); chk("swgap_rst_out", {28'd0, rst_out}, 32'hE);
        goto(19); chk("swgap_rst_out", {28'd0, rst_out}, 32'hC);
        goto(23); chk("swgap_rst_out", {28'd0, rst_out}, 32'hC);

        // Asynchronous rst pulse mid-cycle after edge 23
        @(negedge ck);
        rst = 1'b1;
        #1;
        chk("async_rst_out", {28'd0, rst_out}, 32'hF);
        chk("async_done", {31'd0, done}, 32'h0);
        @(negedge ck);
        rst = 1'b0;
        cur = 0;
        goto(10); chk("restart_rst_out", {28'd0, rst_out}, 32'hF);
        goto(11); chk("restart_rst_out", {28'd0, rst_out}, 32'hE);
        goto(35); chk("restart_rst_out", {28'd0, rst_out}, 32'h0);
        chk("restart_done", {31'd0, done}, 32'h1);

        // Hold on channel 2 until edge 40
        ch_hold = 4'b0100;
        do_reset(2);
        goto(26); chk("hold_stalled", {31'd0, stalled}, 32'h0);
        chk("hold_rst_out", {28'd0, rst_out}, 32'hC);
        goto(27); chk("hold_stalled", {31'd0, stalled}, 32'h1);
        chk("hold_rst_out", {28'd0, rst_out}, 32'hC);
        goto(40); chk("hold_stalled", {31'd0, stalled}, 32'h1);
        chk("hold_rst_out", {28'd0, rst_out}, 32'hC);
        ch_hold = 4'b0000;
        goto(41); chk("hold_stalled", {31'd0, stalled}, 32'h0);
        chk("hold_rst_out", {28'd0, rst_out}, 32'h8);
        goto(48); chk("hold_rst_out", {28'd0, rst_out}, 32'h8);
        goto(49); chk("hold_rst_out", {28'd0, rst_out}, 32'h0);
        chk("hold_done", {31'd0, done}, 32'h1);

        // ch_hold has no effect once DONE
        ch_hold = 4'b1111;
        goto(60); chk("done_hold_rst_out", {28'd0, rst_out}, 32'h0);
        chk("done_hold_done", {31'd0, done}, 32'h1);
        chk("done_hold_stalled", {31'd0, stalled}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
